// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Sends one byte to a PS/2 device: inhibits the clock line, issues the start
// bit, shifts the command, parity and stop bits out on device clock falling
// edges, checks the device ack bit and waits for the bus to return to idle.
//
// Ports
//   clk        system clock, all logic on its rising edge
//   rst        synchronous active-high reset
//   kb_clk     PS/2 clock line as seen on the pad (asynchronous)
//   data       PS/2 data line as seen on the pad (asynchronous)
//   cmd        command byte to send
//   cmd_valid  send request; taken when cmd_ready is also high
//   cmd_ready  high while idle
//   kb_clk_oe  1 = pull the PS/2 clock line low
//   data_oe    1 = pull the PS/2 data line low
//   busy       high from acceptance through the done pulse
//   done       one-cycle pulse at the end of each accepted transfer
//   err        with done: missing ack or timeout; held until next acceptance
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 12000,
   parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kb_clk,
   input  logic       data,
   input  logic [7:0] cmd,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   output logic       kb_clk_oe,
   output logic       data_oe,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int unsigned MaxCycles =
      (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int unsigned CntW = $clog2(MaxCycles + 1);
   localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
   localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle, StInhibit, StReq, StSend, StAck, StWaitIdle, StFin
   } state_e;

   state_e          state_q, state_d;
   logic [2:0]      sync_clk_q, sync_data_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic [9:0]      frame_q, frame_d;
   logic            kb_clk_oe_q, kb_clk_oe_d;
   logic            data_oe_q, data_oe_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            cmd_ready_q, cmd_ready_d;

   logic fe, accept, watched, timeout, line_idle;

   // Oldest synchronizer stage high and the next one low marks a device falling edge.
   assign fe        = sync_clk_q[2] & ~sync_clk_q[1];
   assign line_idle = sync_clk_q[2] & sync_data_q[2];
   assign accept    = cmd_valid & (state_q == StIdle);
   assign watched   = state_q inside {StSend, StAck, StWaitIdle};
   // An edge in the same cycle restarts the count, so it wins over expiry.
   assign timeout   = watched & ~fe & (cnt_q == TimeoutLast);

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         sync_clk_q  <= 3'b111;
         sync_data_q <= 3'b111;
         cnt_q       <= '0;
         bit_cnt_q   <= '0;
         frame_q     <= '0;
         kb_clk_oe_q <= 1'b0;
         data_oe_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cmd_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         sync_clk_q  <= {sync_clk_q[1:0], kb_clk};
         sync_data_q <= {sync_data_q[1:0], data};
         cnt_q       <= cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         frame_q     <= frame_d;
         kb_clk_oe_q <= kb_clk_oe_d;
         data_oe_q   <= data_oe_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (accept) state_d = StInhibit;
         StInhibit:  if (cnt_q == InhibitLast) state_d = StReq;
         StReq:      state_d = StSend;
         StSend: begin
            if (timeout) state_d = StFin;
            else if (fe && bit_cnt_q == 4'd9) state_d = StAck;
         end
         StAck: begin
            if (timeout) state_d = StFin;
            else if (fe) state_d = StWaitIdle;
         end
         StWaitIdle: begin
            if (line_idle) state_d = StFin;
            else if (timeout) state_d = StFin;
         end
         StFin:      state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   // Output and datapath next values; outputs are registered from the next state.
   always_comb begin
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      frame_d   = frame_q;
      err_d     = err_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               frame_d   = {1'b1, ~^cmd, cmd};
               err_d     = 1'b0;
               cnt_d     = '0;
               bit_cnt_d = '0;
            end
         end
         StInhibit: cnt_d = cnt_q + 1'b1;
         StReq:     cnt_d = '0;
         StSend, StAck, StWaitIdle: begin
            cnt_d = fe ? '0 : cnt_q + 1'b1;
            if (state_q == StSend && fe) begin
               frame_d   = {1'b1, frame_q[9:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
            if (state_q == StAck && fe) err_d = sync_data_q[2];
            if (timeout) err_d = 1'b1;
         end
         default: ;
      endcase

      kb_clk_oe_d = (state_d == StInhibit) || (state_d == StReq);
      unique case (state_d)
         StReq:   data_oe_d = 1'b1;
         // Start bit carries over from REQ until the first device edge.
         StSend:  data_oe_d = (state_q != StSend) ? 1'b1 : (fe ? ~frame_q[0] : data_oe_q);
         default: data_oe_d = 1'b0;
      endcase
      busy_d      = (state_d != StIdle);
      done_d      = (state_d == StFin);
      cmd_ready_d = (state_d == StIdle);
   end

   assign kb_clk_oe = kb_clk_oe_q;
   assign data_oe   = data_oe_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign cmd_ready = cmd_ready_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

   localparam int unsigned Inh = 20;
   localparam int unsigned Tmo = 200;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic [7:0] cmd = 8'h00;
   logic       cmd_valid = 1'b0;
   logic       kb_clk, data;
   logic       cmd_ready, kb_clk_oe, data_oe, busy, done, err;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   int kb_oe_cnt = 0;

   // Open-drain bus: either side may pull a line low.
   assign kb_clk = dev_clk & ~kb_clk_oe;
   assign data   = dev_data & ~data_oe;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (kb_clk_oe) kb_oe_cnt <= kb_oe_cnt + 1;
   end

   ps2_host_tx #(
      .INHIBIT_CYCLES(Inh),
      .TIMEOUT_CYCLES(Tmo)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .kb_clk   (kb_clk),
      .data     (data),
      .cmd      (cmd),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .kb_clk_oe(kb_clk_oe),
      .data_oe  (data_oe),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   // Returns at the first falling edge after the accepting rising edge.
   task automatic do_accept(input logic [7:0] b);
      @(negedge clk);
      cmd = b;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Returns at the first falling edge after the host entered SEND.
   task automatic wait_send(output bit ok);
      int k = 0;
      while (!(kb_clk_oe == 1'b0 && data_oe == 1'b1) && k < int'(Inh) + 20) begin
         @(negedge clk);
         k++;
      end
      ok = (kb_clk_oe == 1'b0 && data_oe == 1'b1);
   endtask

   // Device clocks n falling edges; records data_oe late in each low phase.
   task automatic dev_edges(input int n, input logic ack_low, output logic [9:0] bits);
      bits = '0;
      for (int i = 0; i < n; i++) begin
         if (i == 10 && ack_low) dev_data = 1'b0;
         repeat (6) @(negedge clk);
         dev_clk = 1'b0;
         repeat (8) @(negedge clk);
         if (i < 10) bits[i] = data_oe;
         dev_clk = 1'b1;
      end
      repeat (3) @(negedge clk);
      dev_data = 1'b1;
   endtask

   task automatic wait_done(output bit ok);
      int k = 0;
      while (done !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      ok = (done === 1'b1);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
      n_cmp++; if ({kb_clk_oe, data_oe} !== 2'b00) begin n_bad++; $display("FAIL reset_oe: got %b want 00", {kb_clk_oe, data_oe}); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_send_ed;
      int k = 0;
      bit ok;
      logic [9:0] bits;
      do_accept(8'hED);
      n_cmp++; if ({busy, cmd_ready} !== 2'b10) begin n_bad++; $display("FAIL ed_busy_ready: got %b want 10", {busy, cmd_ready}); end
      while (kb_clk_oe === 1'b1 && data_oe === 1'b0 && k < int'(Inh) + 10) begin
         @(negedge clk);
         k++;
      end
      n_cmp++; if (k != int'(Inh)) begin n_bad++; $display("FAIL ed_inhibit_len: got %0d want %0d", k, Inh); end
      n_cmp++; if ({kb_clk_oe, data_oe} !== 2'b11) begin n_bad++; $display("FAIL ed_req_oe: got %b want 11", {kb_clk_oe, data_oe}); end
      @(negedge clk);
      n_cmp++; if ({kb_clk_oe, data_oe} !== 2'b01) begin n_bad++; $display("FAIL ed_send_entry: got %b want 01", {kb_clk_oe, data_oe}); end
      dev_edges(11, 1'b1, bits);
      n_cmp++; if (bits !== 10'h012) begin n_bad++; $display("FAIL ed_bits: got %h want 012", bits); end
      wait_done(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL ed_done: no done pulse"); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ed_err: got %b want 0", err); end
      @(negedge clk);
      n_cmp++; if ({done, cmd_ready, busy} !== 3'b010) begin n_bad++; $display("FAIL ed_after_fin: got %b want 010", {done, cmd_ready, busy}); end
   endtask

   task automatic test_nack;
      bit ok;
      logic [9:0] bits;
      do_accept(8'h00);
      wait_send(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL nack_send: SEND not reached"); end
      dev_edges(11, 1'b0, bits);
      n_cmp++; if (bits !== 10'h0FF) begin n_bad++; $display("FAIL nack_bits: got %h want 0ff", bits); end
      wait_done(ok);
      n_cmp++; if (!ok || err !== 1'b1) begin n_bad++; $display("FAIL nack_err: done %b err %b want 1 1", ok, err); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_timeout;
      int k = 0;
      bit ok;
      do_accept(8'h12);
      wait_send(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_send: SEND not reached"); end
      while (done !== 1'b1 && k < int'(Tmo) + 20) begin
         @(negedge clk);
         k++;
      end
      n_cmp++; if (k != int'(Tmo)) begin n_bad++; $display("FAIL tmo_len: got %0d want %0d", k, Tmo); end
      n_cmp++; if ({kb_clk_oe, data_oe, err} !== 3'b001) begin n_bad++; $display("FAIL tmo_state: got %b want 001", {kb_clk_oe, data_oe, err}); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_send;
      int base;
      bit ok;
      logic [9:0] bits;
      base = done_cnt;
      do_accept(8'hFF);
      wait_send(ok);
      dev_edges(4, 1'b0, bits);
      n_cmp++; if (bits[3:0] !== 4'b0000) begin n_bad++; $display("FAIL rmid_bits: got %b want 0000", bits[3:0]); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if ({kb_clk_oe, data_oe, cmd_ready, busy} !== 4'b0010) begin
         n_bad++; $display("FAIL rmid_state: got %b want 0010", {kb_clk_oe, data_oe, cmd_ready, busy});
      end
      repeat (int'(Tmo) + 50) @(negedge clk);
      n_cmp++; if (done_cnt != base) begin n_bad++; $display("FAIL rmid_no_done: got %0d want %0d", done_cnt, base); end
   endtask

   task automatic test_reset_priority;
      int oe_base;
      @(negedge clk);
      cmd = 8'h55;
      cmd_valid = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      rst = 1'b0;
      oe_base = kb_oe_cnt;
      n_cmp++; if ({cmd_ready, busy, kb_clk_oe} !== 3'b100) begin n_bad++; $display("FAIL rprio_state: got %b want 100", {cmd_ready, busy, kb_clk_oe}); end
      repeat (5) @(negedge clk);
      n_cmp++; if (kb_oe_cnt != oe_base) begin n_bad++; $display("FAIL rprio_no_inhibit: got %0d want %0d", kb_oe_cnt, oe_base); end
   endtask

   task automatic test_back_to_back;
      int base, oe_base;
      bit ok;
      logic [9:0] bits;
      base = done_cnt;
      do_accept(8'h0F);
      repeat (3) @(negedge clk);
      cmd = 8'h55;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_send(ok);
      dev_edges(11, 1'b1, bits);
      n_cmp++; if (bits !== 10'h0F0) begin n_bad++; $display("FAIL b2b_bits: got %h want 0f0", bits); end
      wait_done(ok);
      n_cmp++; if (!ok || err !== 1'b0) begin n_bad++; $display("FAIL b2b_done: done %b err %b want 1 0", ok, err); end
      repeat (2) @(negedge clk);
      oe_base = kb_oe_cnt;
      repeat (int'(Inh) + 20) @(negedge clk);
      n_cmp++; if (done_cnt - base != 1) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 1", done_cnt - base); end
      n_cmp++; if (kb_oe_cnt != oe_base) begin n_bad++; $display("FAIL b2b_no_second: got %0d want %0d", kb_oe_cnt, oe_base); end
   endtask

   initial begin
      test_reset();
      test_send_ed();
      test_nack();
      test_timeout();
      test_reset_mid_send();
      test_reset_priority();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
